// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send transmitter among NUM_REQ byte
// producers. One byte in flight at a time. An optional packet lock keeps
// multi-byte messages contiguous on the line. A missing busy response is
// abandoned after BUSY_TIMEOUT cycles with a one-cycle busy_err pulse.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_en,
  output logic [7:0]                 uart_din,
  input  logic                       uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy_err
);

  localparam int GW = $clog2(NUM_REQ);
  // One spare bit so the counter cannot wrap before the timeout fires.
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t          r_state, w_state_next;
  logic [GW-1:0]   r_grant_id, w_grant_next;
  logic            r_lock, w_lock_next;
  logic [GW-1:0]   r_lock_id, w_lock_id_next;
  logic [7:0]      r_din, w_din_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic            r_busy_err, w_err_next;

  logic [NUM_REQ-1:0] w_cand;
  logic [7:0]         w_byte [NUM_REQ];
  logic               w_found;
  logic [GW-1:0]      w_winner;
  logic               w_accept;
  logic [CW-1:0]      w_cnt_inc;

  // Per-requester candidate qualification and byte extraction. While locked
  // only the owner may be a candidate, and only when it actually offers data.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign w_cand[gi]    = req_valid[gi] & (~r_lock | (r_lock_id == GW'(gi)));
    assign w_byte[gi]    = req_data[8*gi +: 8];
    assign req_ready[gi] = w_accept & (w_winner == GW'(gi));
  end

  // Round-robin search starting just after the last grant. Scanning from the
  // farthest slot back to the nearest lets the nearest candidate win.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = r_grant_id;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(r_grant_id) + k) % NUM_REQ;
      if (w_cand[GW'(idx)]) begin
        w_found  = 1'b1;
        w_winner = GW'(idx);
      end
    end
  end

  // A grant is only possible in IDLE with the transmitter free.
  assign w_accept  = (r_state == S_IDLE) && !uart_tx_busy && w_found;
  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state and next-register logic for the launch/wait sequence.
  always_comb begin
    w_state_next   = r_state;
    w_grant_next   = r_grant_id;
    w_lock_next    = r_lock;
    w_lock_id_next = r_lock_id;
    w_din_next     = r_din;
    w_cnt_next     = r_cnt;
    w_err_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next   = S_LAUNCH;
          w_din_next     = w_byte[w_winner];
          w_grant_next   = w_winner;
          w_lock_next    = ~req_last[w_winner];
          w_lock_id_next = w_winner;
        end
      end
      S_LAUNCH: begin
        w_cnt_next   = '0;
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (uart_tx_busy) begin
          w_state_next = S_WAIT_DONE;
        end else if (w_cnt_inc == CW'(BUSY_TIMEOUT - 1)) begin
          // Counter reaches its limit on this edge: the registered error pulse
          // lands BUSY_TIMEOUT cycles after the uart_en cycle. Lock and
          // grant pointer are left as they were; the byte is dropped.
          w_err_next   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_WAIT_DONE: begin
        if (!uart_tx_busy) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_grant_id <= GW'(NUM_REQ - 1);
      r_lock     <= 1'b0;
      r_lock_id  <= '0;
      r_din      <= 8'h00;
      r_cnt      <= '0;
      r_busy_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_grant_id <= w_grant_next;
      r_lock     <= w_lock_next;
      r_lock_id  <= w_lock_id_next;
      r_din      <= w_din_next;
      r_cnt      <= w_cnt_next;
      r_busy_err <= w_err_next;
    end
  end

  assign uart_en  = (r_state == S_LAUNCH);
  assign uart_din = r_din;
  assign grant_id = r_grant_id;
  assign busy_err = r_busy_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a
// packet-level round-robin model predicts the launch order into a scoreboard,
// and a monitor checks every uart_en launch plus busy_err timing.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           sys_clk = 1'b0;
  logic           sys_rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           uart_en;
  logic [7:0]     uart_din;
  logic           uart_tx_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           busy_err;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_en      (uart_en),
    .uart_din     (uart_din),
    .uart_tx_busy (uart_tx_busy),
    .grant_id     (grant_id),
    .busy_err     (busy_err)
  );

  initial forever begin
    #5 sys_clk = 1'b1;
    cyc++;
    #5 sys_clk = 1'b0;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // Stimulus queues: bit 8 = last flag, bits 7:0 = data.
  typedef logic [8:0] bq_t [$];
  bq_t pq [N];
  int gap [N];
  int gap_mode = 0;        // 0 none, >0 fixed gap after a non-last byte, -1 random
  logic [N-1:0] hs = '0;

  typedef struct packed {logic [1:0] id; logic [7:0] data;} exp_t;
  exp_t exp_q [$];
  int en_cyc [$];

  // Reference model state (packet-level round robin)
  int m_ptr = N - 1;
  bit m_lock = 1'b0;
  int m_lock_id = 0;

  // uart_send model controls
  int fix_d = 0;
  int fix_b = 0;
  bit to_next = 1'b0;
  bit to_rand = 1'b0;
  bit u_active = 1'b0;
  int err_due = -1;
  int n_err_seen = 0;
  logic [7:0] held_din = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Predict launch order from the queued bytes: locked owner first, otherwise
  // the first non-empty requester after the previous grant.
  function automatic void model_load();
    bq_t q [N];
    int total = 0;
    int w;
    logic [8:0] b;
    for (int i = 0; i < N; i++) begin
      q[i] = pq[i];
      total += q[i].size();
    end
    for (int n = 0; n < total; n++) begin
      w = -1;
      if (m_lock && q[m_lock_id].size() > 0) w = m_lock_id;
      else begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && q[(m_ptr + k) % N].size() > 0) w = (m_ptr + k) % N;
        end
      end
      b = q[w].pop_front();
      exp_q.push_back({2'(w), b[7:0]});
      m_ptr = w;
      m_lock = !b[8];
      m_lock_id = w;
    end
  endfunction

  task automatic load_pkts(input int id, input int npkt);
    int len;
    for (int p = 0; p < npkt; p++) begin
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) pq[id].push_back({1'(k == len - 1), 8'($urandom)});
    end
  endtask

  // Requester driver: pops accepted bytes, applies optional mid-packet gaps.
  initial begin
    for (int i = 0; i < N; i++) gap[i] = 0;
    forever begin
      @(negedge sys_clk);
      for (int i = 0; i < N; i++) begin
        if (gap[i] > 0) gap[i]--;
        if (hs[i] && pq[i].size() > 0) begin
          if (pq[i][0][8] == 1'b0)
            gap[i] = (gap_mode < 0) ? int'($urandom_range(0, 5)) : gap_mode;
          void'(pq[i].pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() > 0) begin
          req_valid[i] = (gap[i] == 0);
          req_data[8*i +: 8] = pq[i][0][7:0];
          req_last[i] = pq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
      #1;
      hs = req_valid & req_ready;
    end
  end

  // uart_send model: busy rises d cycles after uart_en and lasts b cycles,
  // or never rises when a timeout is requested.
  initial begin
    int d, b;
    bit to;
    forever begin
      @(negedge sys_clk);
      if (uart_en === 1'b1) begin
        u_active = 1'b1;
        to = to_next || (to_rand && $urandom_range(0, 7) == 0);
        to_next = 1'b0;
        if (to) begin
          err_due = cyc + TO;
          repeat (TO) @(negedge sys_clk);
        end else begin
          d = (fix_d > 0) ? fix_d : int'($urandom_range(1, 4));
          b = (fix_b > 0) ? fix_b : int'($urandom_range(1, 12));
          repeat (d) @(negedge sys_clk);
          uart_tx_busy = 1'b1;
          repeat (b) @(negedge sys_clk);
          uart_tx_busy = 1'b0;
        end
        u_active = 1'b0;
      end
    end
  end

  // Monitor: scoreboard compare on every launch, plus per-cycle invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      #2;
      if (uart_en === 1'b1) begin
        en_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_launch: actual grant=%0d din=%02h required=none (cycle %0d)",
                   grant_id, uart_din, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("launch_din", uart_din, e.data);
          chk("launch_grant", grant_id, e.id);
          held_din = e.data;
          $display("cycle %0d launch req=%0d din=%02h", cyc, grant_id, uart_din);
        end
      end
      if (cyc == err_due) begin
        chk("busy_err_timing", busy_err, 1);
        if (busy_err === 1'b1) n_err_seen++;
        err_due = -1;
      end else if (busy_err !== 1'b0) begin
        chk("busy_err_spurious", busy_err, 0);
      end
      if (uart_tx_busy) begin
        chk("ready_while_busy", req_ready, 0);
        chk("din_hold", uart_din, held_din);
      end
      if (req_ready != '0) chk("ready_onehot", $countones(req_ready), 1);
    end
  end

  task automatic do_reset();
    @(negedge sys_clk);
    #3;
    sys_rst = 1'b1;
    held_din = 8'h00;
    m_ptr = N - 1;
    m_lock = 1'b0;
    m_lock_id = 0;
    @(negedge sys_clk);
    #3;
    sys_rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int t = 0;
    while (t < budget) begin
      @(negedge sys_clk);
      #4;
      t++;
      if (pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 && pq[3].size() == 0 &&
          exp_q.size() == 0 && !u_active && !uart_tx_busy && err_due < 0) break;
    end
    n_cmp++;
    if (t >= budget) begin
      n_fail++;
      $display("FAIL drain_%s: actual=still pending after %0d cycles required=all launched", name, t);
    end
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    int t, e0;

    // Reset values
    do_reset();
    chk("reset_ready", req_ready, 0);
    chk("reset_en", uart_en, 0);
    chk("reset_din", uart_din, 8'h00);
    chk("reset_grant", grant_id, N - 1);
    chk("reset_err", busy_err, 0);

    // Single byte from requester 2
    fix_d = 2;
    fix_b = 6;
    pq[2].push_back({1'b1, 8'hA5});
    model_load();
    t = 0;
    do begin
      @(negedge sys_clk);
      #3;
      t++;
    end while (req_ready == '0 && t < 20);
    chk("single_ready", req_ready, 4'b0100);
    @(negedge sys_clk);
    #3;
    chk("single_en_next", uart_en, 1);
    chk("single_din", uart_din, 8'hA5);
    drain("single", 200);

    // Fairness: all four valid, constant launch spacing
    do_reset();
    fix_d = 1;
    fix_b = 10;
    en_cyc.delete();
    pq[0].push_back({1'b1, 8'h10}); pq[0].push_back({1'b1, 8'h14});
    pq[1].push_back({1'b1, 8'h11}); pq[1].push_back({1'b1, 8'h15});
    pq[2].push_back({1'b1, 8'h12});
    pq[3].push_back({1'b1, 8'h13});
    model_load();
    drain("fair", 400);
    chk("fair_count", en_cyc.size(), 6);
    for (int k = 1; k < en_cyc.size(); k++)
      chk("fair_spacing", en_cyc[k] - en_cyc[k-1], fix_d + fix_b + 2);

    // Packet lock with 20-cycle owner gaps
    fix_d = 1;
    fix_b = 3;
    gap_mode = 20;
    pq[1].push_back({1'b0, 8'hB0}); pq[1].push_back({1'b0, 8'hB1}); pq[1].push_back({1'b1, 8'hB2});
    pq[0].push_back({1'b1, 8'hC0}); pq[0].push_back({1'b1, 8'hC1});
    model_load();
    drain("lock", 500);
    gap_mode = 0;

    // Timeout: first launch gets no busy response
    fix_d = 0;
    fix_b = 0;
    to_next = 1'b1;
    e0 = n_err_seen;
    pq[3].push_back({1'b1, 8'hD3});
    pq[1].push_back({1'b1, 8'hD1});
    model_load();
    drain("timeout", 300);
    chk("timeout_seen", n_err_seen - e0, 1);

    // Reset in WAIT_DONE with lock held by requester 1
    fix_d = 1;
    fix_b = 40;
    pq[1].push_back({1'b0, 8'hE0}); pq[1].push_back({1'b1, 8'hE1});
    exp_q.push_back({2'd1, 8'hE0});
    t = 0;
    do begin
      @(negedge sys_clk);
      #3;
      t++;
    end while (uart_en !== 1'b1 && t < 50);
    chk("rst_first_launch", uart_en, 1);
    pq[0].push_back({1'b1, 8'hF0});
    t = 0;
    do begin
      @(negedge sys_clk);
      #3;
      t++;
    end while (uart_tx_busy !== 1'b1 && t < 20);
    repeat (3) @(negedge sys_clk);
    do_reset();
    chk("rst_busy_still_high", uart_tx_busy, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_en", uart_en, 0);
    chk("rst_din", uart_din, 8'h00);
    chk("rst_grant", grant_id, N - 1);
    chk("rst_err", busy_err, 0);
    model_load();
    drain("reset_mid", 300);

    // Randomized rounds with random busy profiles, timeouts and owner gaps
    fix_d = 0;
    fix_b = 0;
    to_rand = 1'b1;
    gap_mode = -1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) load_pkts(i, $urandom_range(0, 2));
      model_load();
      drain("random", 3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_send` transmitter among up to `NUM_REQ` byte producers. Each requester offers bytes over a valid/ready handshake. The arbiter grants one byte at a time, latches it onto `uart_din`, pulses `uart_en`, and tracks `uart_tx_busy` until the frame completes. An optional packet lock keeps multi-byte messages contiguous on the line. It sits in `uart_loopback_top` between the producers (loop logic, status reporters) and `u_uart_send`.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `BUSY_TIMEOUT`, default 16: cycles to wait for `uart_tx_busy` to rise after `uart_en` before abandoning the byte.
- `sys_clk`, input, 1: system clock, 50 MHz.
- `sys_rst`, input, 1: reset, synchronous, active-high.
- `req_valid`, input, NUM_REQ: requester i has a byte available.
- `req_data`, input, 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `req_last`, input, NUM_REQ: offered byte is the last of its packet.
- `req_ready`, output, NUM_REQ: one-hot; the byte is accepted when valid and ready are both high on the same cycle.
- `uart_en`, output, 1: one-cycle start pulse to `uart_send`.
- `uart_din`, output, 8: byte to `uart_send`, held stable from launch until the frame completes.
- `uart_tx_busy`, input, 1: transmitter busy, from `uart_send`.
- `grant_id`, output, $clog2(NUM_REQ): index of the most recently granted requester.
- `busy_err`, output, 1: one-cycle pulse when `BUSY_TIMEOUT` expires.

## Operation
- FSM states are IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
- **IDLE**
  - Arbitrate only when `uart_tx_busy`=0.
  - Candidate set: if `lock` is set, only `lock_id`; otherwise every i with `req_valid[i]`=1.
  - Winner: first candidate searching upward from `(grant_id+1) mod NUM_REQ`, with wrap-around.
  - `req_ready[winner]`=1 combinationally in that cycle.
  - On the clock edge: `uart_din` <= winner data, `grant_id` <= winner, state goes to LAUNCH.
  - If there is no candidate, remain in IDLE with `req_ready`=0.
- **Lock**
  - An accepted byte with `req_last`=0 sets `lock`=1 and `lock_id`=winner.
  - An accepted byte with `req_last`=1 clears `lock`.
  - While locked, other requesters are never granted, even if the owner deasserts `req_valid`; the arbiter waits for the owner.
- **LAUNCH**: `uart_en`=1 for exactly this cycle; next state is WAIT_BUSY and the timeout counter is cleared.
- **WAIT_BUSY**
  - `uart_tx_busy`=1 moves to WAIT_DONE.
  - Otherwise the counter increments.
  - When the counter reaches `BUSY_TIMEOUT`-1, pulse `busy_err` and go to IDLE. The byte is dropped, and `lock` and `grant_id` are unchanged.
- **WAIT_DONE**: `uart_tx_busy`=0 moves to IDLE.
- `req_ready` is 0 in every state other than IDLE, so at most one byte is in flight.
- Counter width is $clog2(BUSY_TIMEOUT)+1 bits and must not wrap before expiry.

## Timing
- Reset values:
  - state IDLE
  - `req_ready`=0, `uart_en`=0, `uart_din`=8'h00
  - `grant_id`=NUM_REQ-1, so requester 0 has first priority
  - `busy_err`=0, `lock`=0
- Reset mid-frame returns the FSM to IDLE and clears `lock` on the next edge. The frame already started in `uart_send` is not aborted; the arbiter waits in IDLE for `uart_tx_busy`=0 before granting again.
- Handshake to launch: `uart_en` is high exactly 1 cycle after the accepting edge.
- `uart_din` changes only on an accepting edge.
- Minimum gap between two accepts is 3 cycles plus the busy duration: IDLE → LAUNCH → WAIT_BUSY (≥1) → WAIT_DONE (≥1) → IDLE.
- Requests arriving together resolve by round-robin order only; there is no fixed priority.
- `busy_err` is registered and occurs exactly `BUSY_TIMEOUT` cycles after the `uart_en` cycle.

## Test plan
- **Single byte.** After reset, req 2 valid with 8'hA5 and last=1.
  - `req_ready`=4'b0100 in one cycle.
  - `uart_en` pulses on the next cycle with `uart_din`=8'hA5 and `grant_id`=2.
  - No new ready until `uart_tx_busy` falls.
- **Fairness.** All 4 requests held valid with last=1 and a modelled `uart_send` busy of 10 cycles.
  - Grant order is 0, 1, 2, 3, 0, 1.
  - Spacing between `uart_en` pulses is constant.
- **Packet lock.** Req 1 sends 3 bytes (last=0, 0, 1) while req 0 is continuously valid.
  - All three req 1 bytes go out back to back, then req 0.
  - Req 1 drops valid for 20 cycles mid-packet: no grant to req 0 during the gap.
- **Timeout.** `uart_tx_busy` is held at 0 after launch.
  - `busy_err` pulses 16 cycles after `uart_en`.
  - Return to IDLE, and the next request is granted normally.
- **Reset mid-frame.** Assert `sys_rst` in WAIT_DONE with `uart_tx_busy`=1 still high, and lock set.
  - Outputs return to reset values.
  - No grant occurs until busy falls.
  - Req 0 is granted first afterwards, and the lock is cleared.
